// File: rtl/bcd_count3_pkg.sv
// Shared constants and types for the three-digit BCD counter.
// A packed count word holds hundreds in [11:8], tens in [7:4] and units in [3:0].
package conta_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam int         N_DIGITS = 3;
    localparam int         BCD_W    = 4 * N_DIGITS;

    // Digit index within the packed word; digit i occupies bits [4*i+3:4*i].
    localparam int DIG_UNI = 0;
    localparam int DIG_TEN = 1;
    localparam int DIG_HUN = 2;

    typedef logic [3:0] bcd_digit_t;

    // Clamp a nibble into the legal decimal range so stored state is always BCD.
    function automatic bcd_digit_t sat_digit(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_count3_if.sv
// Control and display bundle between the counter and its user.
// All controls are level signals sampled on the rising clk edge; no valid/ready pairing.
interface bcd_count3_if;
    import conta_pkg::*;

    logic             en;
    logic             up_dn;
    logic             src_sel;
    logic             ext_step;
    logic             clr;
    logic             load;
    logic [BCD_W-1:0] load_val;
    logic [BCD_W-1:0] bcd;
    logic [2:0]       blank;
    logic             wrap;

    modport master (
        output en, up_dn, src_sel, ext_step, clr, load, load_val,
        input  bcd, blank, wrap
    );

    modport slave (
        input  en, up_dn, src_sel, ext_step, clr, load, load_val,
        output bcd, blank, wrap
    );

endinterface

// File: rtl/bcd_count3_digit.sv
// One decade of the BCD chain; carry/borrow outs are combinational so the
// whole chain ripples within a single clock.
module bcd_digit
    import conta_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    input  logic       clr,
    output bcd_digit_t q,
    output logic       co,
    output logic       bo
);

    assign co = inc && (q == BCD_MAX);
    assign bo = dec && (q == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (ld) begin
            q <= sat_digit(ld_val);
        end else if (inc) begin
            q <= co ? 4'd0 : q + 4'd1;
        end else if (dec) begin
            q <= bo ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_count3.sv
// Three-digit BCD up/down counter feeding the multiplexed 7-segment driver.
// Steps on an internal prescaled tick or a synchronised external pulse.
module bcd_count3
    import conta_pkg::*;
#(
    parameter int PRESCALE = 1_000_000,
    parameter int PW       = 20
) (
    input logic          clk,
    input logic          rst_n,
    bcd_count3_if.slave  bus
);

    logic [PW-1:0]     presc;
    logic              tick;
    logic [2:0]        sync;
    logic              ext_edge;
    logic              step;
    logic              do_step;
    logic [N_DIGITS:0] inc_c;
    logic [N_DIGITS:0] dec_c;
    logic [BCD_W-1:0]  bcd_q;
    logic              wrap_q;

    assign tick = bus.en && !bus.src_sel && (presc == PW'(PRESCALE - 1));

    // Prescaler only advances in internal mode, so switching sources freezes it in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (bus.clr) begin
            presc <= '0;
        end else if (bus.en && !bus.src_sel) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    // sync[2] always tracks sync[1], which also gives clr its "history = current level".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 3'b000;
        end else begin
            sync <= {sync[1], sync[0], bus.ext_step};
        end
    end

    assign ext_edge = sync[1] && !sync[2];
    assign step     = bus.en && (bus.src_sel ? ext_edge : tick);
    assign do_step  = step && !bus.clr && !bus.load;
    assign inc_c[0] = do_step && bus.up_dn;
    assign dec_c[0] = do_step && !bus.up_dn;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc    (inc_c[i]),
            .dec    (dec_c[i]),
            .ld     (bus.load),
            .ld_val (bus.load_val[4*i +: 4]),
            .clr    (bus.clr),
            .q      (bcd_q[4*i +: 4]),
            .co     (inc_c[i+1]),
            .bo     (dec_c[i+1])
        );
    end

    // A carry or borrow out of the top digit is exactly a 999<->000 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= inc_c[N_DIGITS] || dec_c[N_DIGITS];
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.wrap     = wrap_q;
    assign bus.blank[2] = (bcd_q[4*DIG_HUN +: 4] == 4'd0);
    assign bus.blank[1] = (bcd_q[4*DIG_HUN +: 4] == 4'd0) && (bcd_q[4*DIG_TEN +: 4] == 4'd0);
    assign bus.blank[0] = 1'b0;

endmodule

// File: tb/tb_bcd_count3.sv
// Directed bench for bcd_count3: vector table for load/clear/step behaviour,
// plus hand sequences for counting from reset, priority, external step and async reset.
module tb_bcd_count3;
    import conta_pkg::*;

    localparam int PRESCALE = 4;
    localparam int PW       = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bcd_count3_if bus ();

    bcd_count3 #(.PRESCALE(PRESCALE), .PW(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_q[$];

    typedef enum logic [1:0] {OP_LOAD, OP_CLR, OP_UP, OP_DN} op_e;
    typedef struct {
        op_e         op;
        logic [11:0] val;
        logic [11:0] exp_bcd;
        logic [2:0]  exp_blank;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [11:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        cyc(1);
        bus.load     = 1'b0;
    endtask

    // One-cycle external pulse; the count updates on the third edge counting the sampling edge.
    task automatic ext_step_once(input logic dir);
        bus.up_dn    = dir;
        bus.ext_step = 1'b1;
        cyc(1);
        bus.ext_step = 1'b0;
        cyc(2);
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.up_dn    = 1'b1;
        bus.src_sel  = 1'b0;
        bus.ext_step = 1'b0;
        bus.clr      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 12'h000;

        vecs[0]  = '{OP_LOAD, 12'h099, 12'h099, 3'b100, 1'b0};
        vecs[1]  = '{OP_UP,   12'h000, 12'h100, 3'b000, 1'b0};
        vecs[2]  = '{OP_LOAD, 12'h999, 12'h999, 3'b000, 1'b0};
        vecs[3]  = '{OP_UP,   12'h000, 12'h000, 3'b110, 1'b1};
        vecs[4]  = '{OP_LOAD, 12'h100, 12'h100, 3'b000, 1'b0};
        vecs[5]  = '{OP_DN,   12'h000, 12'h099, 3'b100, 1'b0};
        vecs[6]  = '{OP_CLR,  12'h000, 12'h000, 3'b110, 1'b0};
        vecs[7]  = '{OP_DN,   12'h000, 12'h999, 3'b000, 1'b1};
        vecs[8]  = '{OP_LOAD, 12'hA5F, 12'h959, 3'b000, 1'b0};
        vecs[9]  = '{OP_LOAD, 12'h9AF, 12'h999, 3'b000, 1'b0};
        vecs[10] = '{OP_DN,   12'h000, 12'h998, 3'b000, 1'b0};
        vecs[11] = '{OP_UP,   12'h000, 12'h999, 3'b000, 1'b0};
        vecs[12] = '{OP_LOAD, 12'h005, 12'h005, 3'b110, 1'b0};
        vecs[13] = '{OP_DN,   12'h000, 12'h004, 3'b110, 1'b0};
        vecs[14] = '{OP_LOAD, 12'h010, 12'h010, 3'b100, 1'b0};
        vecs[15] = '{OP_DN,   12'h000, 12'h009, 3'b110, 1'b0};
        vecs[16] = '{OP_UP,   12'h000, 12'h010, 3'b100, 1'b0};

        // Reset state
        #1 rst_n = 1'b0;
        cyc(1);
        check("rst_bcd",   bus.bcd,          12'h000);
        check("rst_blank", {9'd0, bus.blank}, 12'h006);
        check("rst_wrap",  {11'd0, bus.wrap}, 12'h000);

        // Internal counting from release: one step every PRESCALE edges
        bus.en      = 1'b1;
        bus.up_dn   = 1'b1;
        bus.src_sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            check($sformatf("int_up_k%0d", k), bus.bcd, 12'(k / PRESCALE));
            check($sformatf("int_blank_k%0d", k), {9'd0, bus.blank}, 12'h006);
        end

        // Table vectors in external mode so the bench controls each step
        bus.src_sel = 1'b1;
        cyc(2);
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(vecs[i].exp_bcd);
            case (vecs[i].op)
                OP_LOAD: do_load(vecs[i].val);
                OP_CLR: begin
                    bus.clr = 1'b1;
                    cyc(1);
                    bus.clr = 1'b0;
                end
                OP_UP:   ext_step_once(1'b1);
                default: ext_step_once(1'b0);
            endcase
            check($sformatf("vec%0d_bcd", i), bus.bcd, exp_q.pop_front());
            check($sformatf("vec%0d_blank", i), {9'd0, bus.blank}, {9'd0, vecs[i].exp_blank});
            check($sformatf("vec%0d_wrap", i), {11'd0, bus.wrap}, {11'd0, vecs[i].exp_wrap});
            cyc(1);
            check($sformatf("vec%0d_wrap_drop", i), {11'd0, bus.wrap}, 12'h000);
        end

        // clr + load + step on the same edge: clear wins, step is dropped
        do_load(12'h999);
        bus.up_dn    = 1'b1;
        bus.ext_step = 1'b1;
        cyc(1);
        bus.ext_step = 1'b0;
        cyc(1);
        bus.clr      = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 12'h123;
        cyc(1);
        bus.clr      = 1'b0;
        bus.load     = 1'b0;
        check("prio_clr_bcd",  bus.bcd,          12'h000);
        check("prio_clr_wrap", {11'd0, bus.wrap}, 12'h000);
        cyc(1);
        check("prio_clr_hold", bus.bcd,          12'h000);
        check("prio_clr_wrap2", {11'd0, bus.wrap}, 12'h000);

        // load + step on the same edge: only the load lands
        do_load(12'h999);
        bus.ext_step = 1'b1;
        cyc(1);
        bus.ext_step = 1'b0;
        cyc(1);
        bus.load     = 1'b1;
        bus.load_val = 12'h321;
        cyc(1);
        bus.load     = 1'b0;
        check("prio_load_bcd",  bus.bcd,          12'h321);
        check("prio_load_wrap", {11'd0, bus.wrap}, 12'h000);
        cyc(1);
        check("prio_load_hold", bus.bcd,          12'h321);

        // External level held for 10 edges steps exactly once
        do_load(12'h041);
        bus.ext_step = 1'b1;
        cyc(1);
        check("ext_lvl_e1", bus.bcd, 12'h041);
        cyc(1);
        check("ext_lvl_e2", bus.bcd, 12'h041);
        cyc(1);
        check("ext_lvl_e3", bus.bcd, 12'h042);
        cyc(7);
        check("ext_lvl_e10", bus.bcd, 12'h042);
        bus.ext_step = 1'b0;
        cyc(3);
        check("ext_lvl_after", bus.bcd, 12'h042);

        // Pulses while disabled are discarded, not deferred
        bus.en = 1'b0;
        repeat (3) begin
            bus.ext_step = 1'b1;
            cyc(1);
            bus.ext_step = 1'b0;
            cyc(3);
        end
        check("en0_pulses", bus.bcd, 12'h042);
        bus.en = 1'b1;
        cyc(3);
        check("en0_no_defer", bus.bcd, 12'h042);

        // Async reset mid-count with the prescaler at 2
        bus.clr = 1'b1;
        cyc(1);
        bus.clr = 1'b0;
        check("mid_clr", bus.bcd, 12'h000);
        do_load(12'h457);
        check("mid_load", bus.bcd, 12'h457);
        bus.src_sel = 1'b0;
        cyc(2);
        check("mid_presc2", bus.bcd, 12'h457);
        #2 rst_n = 1'b0;
        #1;
        check("async_bcd",   bus.bcd,          12'h000);
        check("async_blank", {9'd0, bus.blank}, 12'h006);
        check("async_wrap",  {11'd0, bus.wrap}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        check("rel_e3", bus.bcd, 12'h000);
        cyc(1);
        check("rel_e4", bus.bcd, 12'h001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
